alu_div: RTL
============

ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a division; sampled on rising clk.
REQ-006 sign  input  1  1 = signed two's-complement divide, 0 = unsigned; sampled with start.
REQ-007 data0  input  WIDTH  dividend; sampled with start.
REQ-008 data1  input  WIDTH  divisor; sampled with start.
REQ-009 busy  output  1  division in progress; new start ignored.
REQ-010 done  output  1  one-cycle pulse: quot/rem/div_zero valid.
REQ-011 quot  output  WIDTH  quotient, registered.
REQ-012 rem  output  WIDTH  remainder, registered.
REQ-013 div_zero  output  1  last completed operation had data1 == 0.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX, DONE; reset state is IDLE.
REQ-015 IDLE: start=1 at an edge latches data0, data1, sign and enters CALC; start=0 stays IDLE.
REQ-016 Latch step: signed mode converts both operands to magnitudes and records quotient sign (sign0 XOR sign1) and remainder sign (sign0); unsigned mode uses operands as-is.
REQ-017 CALC: restoring shift-subtract, one quotient bit per cycle, MSB first, exactly WIDTH cycles counted by an internal counter, then FIX.
REQ-018 FIX: applies sign correction (negate quotient/remainder per REQ-016), writes quot, rem, div_zero, enters DONE; 1 cycle.
REQ-019 DONE: done=1 for exactly this cycle; next state IDLE, or CALC if start=1 (back-to-back accept, operands latched per REQ-016).
REQ-020 Latency SHALL be fixed: start sampled at edge k -> done high in the cycle following edge k+WIDTH+2, for every operand value including divide-by-zero.
REQ-021 busy SHALL be 1 in CALC and FIX, 0 in IDLE and DONE.
REQ-022 start while busy=1 SHALL be ignored with no effect on the running operation or outputs.
REQ-023 Signed results SHALL truncate toward zero; rem sign equals dividend sign; dividend = quot*divisor + rem holds.
REQ-024 Divisor 0: quot = all ones, rem = data0 (unmodified), div_zero=1, in both modes.
REQ-025 Signed overflow (data0 = most-negative, data1 = -1): quot = most-negative value, rem = 0, div_zero=0.
REQ-026 quot, rem, div_zero SHALL hold their values from FIX until the next FIX; they do not change during a subsequent CALC.
REQ-027 Intermediate remainder SHALL be WIDTH+1 bits wide so subtraction never loses the carry.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, busy=0, done=0, quot=0, rem=0, div_zero=0, independent of clk.
REQ-029 Reset asserted mid-CALC SHALL abort the operation with no done pulse; first start after release begins a fresh division.
REQ-030 start sampled at the first edge after rst_n deasserts SHALL be accepted.

Verification
REQ-031 Unsigned: data0=100, data1=7, sign=0 -> done at edge k+34 (WIDTH=32), quot=14, rem=2, div_zero=0.
REQ-032 Signed: data0=-7 (0xFFFFFFF9), data1=2, sign=1 -> quot=-3 (0xFFFFFFFD), rem=-1 (0xFFFFFFFF); also 7/-2 -> quot=-3, rem=1.
REQ-033 Divide-by-zero: data0=0x12345678, data1=0 -> quot=0xFFFFFFFF, rem=0x12345678, div_zero=1, same latency as REQ-031.
REQ-034 Overflow: data0=0x80000000, data1=0xFFFFFFFF, sign=1 -> quot=0x80000000, rem=0; same operands sign=0 -> quot=0, rem=0x80000000.
REQ-035 Handshake: start pulsed during CALC with other operands -> ignored, result of first op unchanged; start=1 in DONE cycle -> second op accepted, its done exactly 34 cycles later.
REQ-036 Reset mid-op: rst_n low at cycle 10 of CALC -> all outputs 0 asynchronously, no done pulse; subsequent 100/7 yields 14/2.

Source files
------------

// File: rtl/alu_div.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle.
// Fixed latency: start at edge k gives done after edge k+WIDTH+2; start is ignored while busy.
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divz_q, divz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mag0, mag1;
  logic             load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    divz_d  = divz_q;

    // dvd_q doubles as the quotient: dividend bits shift out the top, quotient bits in the bottom
    shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    mag0    = (sign && data0[WIDTH-1]) ? -data0 : data0;
    mag1    = (sign && data1[WIDTH-1]) ? -data1 : data1;
    load    = start && (state_q == IDLE || state_q == DONE);

    case (state_q)
      IDLE: state_d = IDLE;
      CALC: begin
        // the terminal-count cycle performs no step; it only hands over to FIX
        if (cnt_q == CW'(WIDTH)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (diff[WIDTH]) begin
            prem_d = shifted;
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
          end else begin
            prem_d = diff;
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
          end
        end
      end
      FIX: begin
        quot_d  = dz_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
        rem_d   = rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
        divz_d  = dz_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // with a zero divisor the remainder path returns the dividend magnitude, re-signed back to data0
    if (load) begin
      dvd_d   = mag0;
      dvs_d   = mag1;
      prem_d  = '0;
      cnt_d   = '0;
      qneg_d  = sign && (data0[WIDTH-1] ^ data1[WIDTH-1]);
      rneg_d  = sign && data0[WIDTH-1];
      dz_d    = (data1 == '0);
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = divz_q;

endmodule
